// File: rtl/ovi_issue_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ovi_issue_sequencer_pkg
//   Shared definitions for the OVI vector-issue engine: the bus structs used
//   between the scalar front end and the vector core, the sequencer FSM state
//   type and the instruction-buffer entry type.
//
//   Width macros OVI_INSTR_WIDTH / OVI_VL_WIDTH / OVI_SEW_WIDTH get defaults
//   here when the build does not provide them.
//   Optional feature macro used by the top level: OVI_ISSUE_PERF_EN.
// ---------------------------------------------------------------------------
`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 8
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif

package ovi_issue_sequencer_pkg;

  localparam int INSTR_W = `OVI_INSTR_WIDTH;
  localparam int VL_W    = `OVI_VL_WIDTH;
  localparam int SEW_W   = `OVI_SEW_WIDTH;

  // Issue bus towards the vector core; the core accepts every valid cycle.
  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [VL_W-1:0]    vl;
    logic [SEW_W-1:0]   sew;
  } core_issue_bus;

  // Completion bus from the vector core; one valid cycle retires one instruction.
  typedef struct packed {
    logic valid;
  } core_completed_bus;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Buffered instruction together with the vl/sew that were live when it was pushed.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [VL_W-1:0]    vl;
    logic [SEW_W-1:0]   sew;
  } issue_entry_t;

  function automatic issue_entry_t make_entry(input logic [INSTR_W-1:0] instr,
                                              input logic [VL_W-1:0]    vl,
                                              input logic [SEW_W-1:0]   sew);
    issue_entry_t e;
    e.instr = instr;
    e.vl    = vl;
    e.sew   = sew;
    return e;
  endfunction

endpackage

// File: rtl/ovi_issue_fifo.sv
// ---------------------------------------------------------------------------
// ovi_issue_fifo
//   Synchronous-write, combinational-read instruction buffer. Read and write
//   pointers are one bit wider than the index so full and empty fall out of a
//   plain pointer compare. A push while full is only taken if a pop happens in
//   the same cycle, so occupancy then stays unchanged.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (empties the buffer)
//   push_i   in   write wdata_i on this edge
//   pop_i    in   discard the head entry on this edge
//   wdata_i  in   entry to write
//   rdata_o  out  current head entry (valid when !empty_o)
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   count_o  out  current occupancy
// ---------------------------------------------------------------------------
module ovi_issue_fifo
  import ovi_issue_sequencer_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = issue_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [IDX_W:0]   wrPtr_q, wrPtr_d;
  logic [IDX_W:0]   rdPtr_q, rdPtr_d;
  logic             pushEn;
  logic             popEn;

  // Accept/advance decisions; pushing into a full buffer needs a same-cycle pop.
  always_comb begin
    popEn   = pop_i && !empty_o;
    pushEn  = push_i && (!full_o || popEn);
    wrPtr_d = pushEn ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = popEn  ? rdPtr_q + 1'b1 : rdPtr_q;
  end

  // Full when the pointers differ only in the wrap bit, empty when identical.
  always_comb begin
    empty_o = (wrPtr_q == rdPtr_q);
    full_o  = (wrPtr_q[IDX_W] != rdPtr_q[IDX_W]) &&
              (wrPtr_q[IDX_W-1:0] == rdPtr_q[IDX_W-1:0]);
    count_o = wrPtr_q - rdPtr_q;
    rdata_o = mem_q[rdPtr_q[IDX_W-1:0]];
  end

  // Pointer registers; reset simply forgets everything stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array has no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (pushEn) begin
      mem_q[wrPtr_q[IDX_W-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ovi_issue_sequencer.sv
// ---------------------------------------------------------------------------
// ovi_issue_sequencer
//   OVI vector-issue engine. Buffers instructions from the scalar front end
//   (each tagged with the vl/sew live at push time), issues them to the vector
//   core with at most MAX_OUTSTANDING in flight, retires them on completion,
//   supports halt-with-drain and flags completions that arrive with nothing in
//   flight as a sticky protocol error.
//
// Optional feature macro: OVI_ISSUE_PERF_EN adds perf_issued_o/perf_stall_o.
//
// Ports
//   clk_i            in   clock, rising edge
//   rst_ni           in   asynchronous active-low reset
//   core_halt_i      in   halt request from the scalar core
//   instr_valid_i    in   push request
//   instr_data_i     in   instruction to push
//   instr_ready_o    out  buffer not full
//   cfg_we_i         in   vl/sew write strobe
//   cfg_vl_i         in   new vl
//   cfg_sew_i        in   new sew
//   core_completed_i in   completion from the vector core
//   core_issue_o     out  instr/vl/sew/valid to the vector core
//   outstanding_o    out  issued-but-not-completed count
//   idle_o           out  IDLE or HALTED with nothing outstanding
//   proto_err_o      out  sticky protocol error
//   perf_issued_o    out  (OVI_ISSUE_PERF_EN) issue cycle count
//   perf_stall_o     out  (OVI_ISSUE_PERF_EN) stalled ISSUE cycle count
// ---------------------------------------------------------------------------
module ovi_issue_sequencer
  import ovi_issue_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int VL_RESET        = 8,
  parameter int SEW_RESET       = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   core_halt_i,
  input  logic                                   instr_valid_i,
  input  logic [`OVI_INSTR_WIDTH-1:0]            instr_data_i,
  output logic                                   instr_ready_o,
  input  logic                                   cfg_we_i,
  input  logic [`OVI_VL_WIDTH-1:0]               cfg_vl_i,
  input  logic [`OVI_SEW_WIDTH-1:0]              cfg_sew_i,
  input  core_completed_bus                      core_completed_i,
  output core_issue_bus                          core_issue_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   idle_o,
  output logic                                   proto_err_o
`ifdef OVI_ISSUE_PERF_EN
  ,
  output logic [31:0]                            perf_issued_o,
  output logic [31:0]                            perf_stall_o
`endif
);

  localparam int                OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  state_t             state_q, state_d;
  logic [VL_W-1:0]    vl_q, vl_d;
  logic [SEW_W-1:0]   sew_q, sew_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic               protoErr_q, protoErr_d;

  issue_entry_t       pushEntry;
  issue_entry_t       headEntry;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CNT_W-1:0]   fifoCount;
  logic               issueFire;
  logic               pushFire;
  logic               fifoDrains;

  // Issue is a pure function of registered state plus the halt input; the core
  // has no ready, so every valid cycle is a pop. Pushing into a full buffer is
  // allowed only when that same cycle pops.
  always_comb begin
    issueFire  = (state_q == ISSUE) && !fifoEmpty &&
                 (outstanding_q < OUT_MAX) && !core_halt_i;
    pushFire   = instr_valid_i && (!fifoFull || issueFire);
    pushEntry  = make_entry(instr_data_i, vl_q, sew_q);
    fifoDrains = fifoEmpty ||
                 ((fifoCount == CNT_W'(1)) && issueFire && !pushFire);
  end

  ovi_issue_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (issue_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (pushFire),
    .pop_i   (issueFire),
    .wdata_i (pushEntry),
    .rdata_o (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Live vl/sew; a push in the same cycle as a write still captures the old values.
  always_comb begin
    vl_d  = vl_q;
    sew_d = sew_q;
    if (cfg_we_i) begin
      vl_d  = cfg_vl_i;
      sew_d = cfg_sew_i;
    end
  end

  // Credit counter: issue and completion in one cycle cancel out. A lone
  // completion with nothing in flight is a protocol error and the count holds at 0.
  always_comb begin
    outstanding_d = outstanding_q;
    protoErr_d    = protoErr_q;
    case ({issueFire, core_completed_i.valid})
      2'b10: outstanding_d = outstanding_q + 1'b1;
      2'b01: begin
        if (outstanding_q == '0) begin
          protoErr_d = 1'b1;
        end else begin
          outstanding_d = outstanding_q - 1'b1;
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sequencer FSM. DRAIN looks at the post-completion count so a final
  // completion lands in HALTED on the next edge without an extra cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (core_halt_i) begin
          state_d = (outstanding_q == '0) ? HALTED : DRAIN;
        end else if (!fifoEmpty) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (core_halt_i) begin
          state_d = DRAIN;
        end else if (fifoDrains) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (!core_halt_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All control state; reset drops buffered and in-flight work together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      vl_q          <= VL_W'(VL_RESET);
      sew_q         <= SEW_W'(SEW_RESET);
      outstanding_q <= '0;
      protoErr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vl_q          <= vl_d;
      sew_q         <= sew_d;
      outstanding_q <= outstanding_d;
      protoErr_q    <= protoErr_d;
    end
  end

  // Issue payload always comes from the buffered entry, never from vl_q/sew_q.
  always_comb begin
    core_issue_o.valid = issueFire;
    core_issue_o.instr = headEntry.instr;
    core_issue_o.vl    = headEntry.vl;
    core_issue_o.sew   = headEntry.sew;
    instr_ready_o      = !fifoFull;
    outstanding_o      = outstanding_q;
    idle_o             = ((state_q == IDLE) || (state_q == HALTED)) &&
                         (outstanding_q == '0);
    proto_err_o        = protoErr_q;
  end

`ifdef OVI_ISSUE_PERF_EN
  logic [31:0] perfIssued_q, perfIssued_d;
  logic [31:0] perfStall_q, perfStall_d;

  // A stall is an ISSUE cycle with work buffered that still did not issue
  // (credit exhausted or halt just raised).
  always_comb begin
    perfIssued_d = issueFire ? perfIssued_q + 32'd1 : perfIssued_q;
    perfStall_d  = ((state_q == ISSUE) && !fifoEmpty && !issueFire) ?
                   perfStall_q + 32'd1 : perfStall_q;
  end

  // Free-running counters that wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perfIssued_q <= '0;
      perfStall_q  <= '0;
    end else begin
      perfIssued_q <= perfIssued_d;
      perfStall_q  <= perfStall_d;
    end
  end

  assign perf_issued_o = perfIssued_q;
  assign perf_stall_o  = perfStall_q;
`endif

endmodule
